// File: rtl/ddr_frame_arbiter_pkg.sv
// Shared map for the DDR frame arbiter: FSM encoding and default
// frame-buffer geometry used by the cam and VGA paths.
package ddr_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_CMD,
        ST_WAIT
    } arb_state_t;

    localparam int BURST_LEN_DEF   = 64;
    localparam int FRAME_WORDS_DEF = 153600;
    localparam int BUF0_BASE_DEF   = 0;
    localparam int BUF1_BASE_DEF   = 262144;
    localparam int RD_LOW_WM_DEF   = 128;
    localparam int RD_FIFO_DEP_DEF = 512;

endpackage

// File: rtl/ddr_frame_arbiter_addr_gen.sv
// Per-side frame offset counter: clamps the burst length at frame end,
// wraps the offset and selects the buffer base address.
module frame_addr_gen
    import ddr_frame_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int LEN_W       = 7,
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int BUF0_BASE   = BUF0_BASE_DEF,
    parameter int BUF1_BASE   = BUF1_BASE_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_adv,
    input  logic              i_buf_sel,
    output logic [ADDR_W-1:0] o_addr,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] L_FRAME = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] L_BURST = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] L_BASE0 = ADDR_W'(BUF0_BASE);
    localparam logic [ADDR_W-1:0] L_BASE1 = ADDR_W'(BUF1_BASE);

    logic [ADDR_W-1:0] r_offset;
    logic [ADDR_W-1:0] w_remain;
    logic [ADDR_W-1:0] w_len;

    assign w_remain = L_FRAME - r_offset;
    assign w_len    = (w_remain < L_BURST) ? w_remain : L_BURST;
    assign o_len    = LEN_W'(w_len);
    assign o_last   = (r_offset + w_len) >= L_FRAME;
    assign o_addr   = (i_buf_sel ? L_BASE1 : L_BASE0) + r_offset;

    // Offset moves only when a burst completes; a frame restart wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_offset <= '0;
        end else if (i_clear) begin
            r_offset <= '0;
        end else if (i_adv) begin
            r_offset <= o_last ? '0 : r_offset + w_len;
        end
    end

endmodule

// File: rtl/ddr_frame_arbiter.sv
// Shares the DDR user port between camera writes and VGA reads,
// ping-ponging two frame buffers so display never sees a partial frame.
module ddr_frame_arbiter
    import ddr_frame_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int LVL_W       = 10,
    parameter int LEN_W       = 7,
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int BUF0_BASE   = BUF0_BASE_DEF,
    parameter int BUF1_BASE   = BUF1_BASE_DEF,
    parameter int RD_LOW_WM   = RD_LOW_WM_DEF,
    parameter int RD_FIFO_DEP = RD_FIFO_DEP_DEF
) (
    input  logic              ddr_clk,
    input  logic              ddr_rst,
    input  logic              ddr_init_done,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_level,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic              cmd_valid,
    output logic              cmd_rw,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    output logic              wr_buf_sel,
    output logic              rd_buf_sel,
    output logic              busy
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic              r_wr_buf_sel;
    logic              r_rd_buf_sel;
    logic              r_done_buf;
    logic              r_wr_pend;
    logic              r_rd_pend;
    logic              r_wr_hold;
    logic              r_prefer_rd;
    logic              r_cmd_rw;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [LEN_W-1:0]  r_cmd_len;

    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [LEN_W-1:0]  w_wr_len;
    logic [LEN_W-1:0]  w_rd_len;
    logic              w_wr_last;
    logic              w_rd_last;
    logic              w_in_burst;
    logic              w_exit;
    logic              w_wr_apply;
    logic              w_rd_apply;
    logic              w_wr_adv;
    logic              w_rd_adv;
    logic              w_wr_wrap;
    logic              w_done_nxt;
    logic              w_rd_urgent;
    logic              w_wr_ok;
    logic              w_rd_room;
    logic              w_tie;
    logic              w_pick_rd;
    logic              w_grant;
    logic              w_launch;

    assign w_in_burst = (r_state == ST_CMD) || (r_state == ST_WAIT);
    assign w_exit     = (r_state == ST_WAIT) && cmd_done;
    assign w_wr_apply = (wr_frame_start || r_wr_pend) && (!w_in_burst || w_exit);
    assign w_rd_apply = (rd_frame_start || r_rd_pend) && (!w_in_burst || w_exit);
    assign w_wr_adv   = w_exit && r_cmd_rw;
    assign w_rd_adv   = w_exit && !r_cmd_rw;
    assign w_wr_wrap  = w_wr_adv && w_wr_last;
    assign w_done_nxt = w_wr_wrap ? r_wr_buf_sel : r_done_buf;

    assign w_rd_urgent = 32'(rd_fifo_level) < 32'(RD_LOW_WM);
    assign w_wr_ok     = !r_wr_hold && (32'(wr_fifo_level) >= 32'(w_wr_len));
    assign w_rd_room   = (32'(rd_fifo_level) + 32'(BURST_LEN)) <= 32'(RD_FIFO_DEP);
    assign w_tie       = !w_rd_urgent && w_wr_ok && w_rd_room;
    assign w_pick_rd   = w_rd_urgent || (w_tie ? r_prefer_rd : !w_wr_ok);
    // A frame restart in ARB takes effect first; the decision waits a cycle.
    assign w_grant     = (w_rd_urgent || w_wr_ok || w_rd_room)
                         && !w_wr_apply && !w_rd_apply;
    assign w_launch    = (r_state == ST_ARB) && (w_state_nxt == ST_CMD);

    frame_addr_gen #(
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .BUF0_BASE   (BUF0_BASE),
        .BUF1_BASE   (BUF1_BASE)
    ) u_wr_gen (
        .i_clk     (ddr_clk),
        .i_rst     (ddr_rst),
        .i_clear   (w_wr_apply),
        .i_adv     (w_wr_adv),
        .i_buf_sel (r_wr_buf_sel),
        .o_addr    (w_wr_addr),
        .o_len     (w_wr_len),
        .o_last    (w_wr_last)
    );

    frame_addr_gen #(
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .BUF0_BASE   (BUF0_BASE),
        .BUF1_BASE   (BUF1_BASE)
    ) u_rd_gen (
        .i_clk     (ddr_clk),
        .i_rst     (ddr_rst),
        .i_clear   (w_rd_apply),
        .i_adv     (w_rd_adv),
        .i_buf_sel (r_rd_buf_sel),
        .o_addr    (w_rd_addr),
        .o_len     (w_rd_len),
        .o_last    (w_rd_last)
    );

    // State register.
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: an accepted burst always runs to cmd_done.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (ddr_init_done) w_state_nxt = ST_ARB;
            end
            ST_ARB: begin
                if (!ddr_init_done) w_state_nxt = ST_IDLE;
                else if (w_grant)   w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (!ddr_init_done) w_state_nxt = ST_IDLE;
                else if (cmd_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    w_state_nxt = ddr_init_done ? ST_ARB : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the command fields at the arbitration decision.
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_cmd_rw    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_len   <= '0;
            r_prefer_rd <= 1'b0;
        end else if (w_launch) begin
            r_cmd_rw   <= !w_pick_rd;
            r_cmd_addr <= w_pick_rd ? w_rd_addr : w_wr_addr;
            r_cmd_len  <= w_pick_rd ? w_rd_len : w_wr_len;
            if (w_tie) r_prefer_rd <= !r_prefer_rd;
        end
    end

    // Buffer ping-pong, deferred frame pulses and the post-frame write hold.
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_wr_buf_sel <= 1'b0;
            r_rd_buf_sel <= 1'b1;
            r_done_buf   <= 1'b1;
            r_wr_pend    <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_wr_hold    <= 1'b0;
        end else begin
            r_done_buf <= w_done_nxt;
            if (w_wr_apply) begin
                r_wr_pend    <= 1'b0;
                r_wr_hold    <= 1'b0;
                r_wr_buf_sel <= !w_done_nxt;
            end else begin
                if (wr_frame_start) r_wr_pend <= 1'b1;
                if (w_wr_wrap)      r_wr_hold <= 1'b1;
            end
            if (w_rd_apply) begin
                r_rd_pend    <= 1'b0;
                r_rd_buf_sel <= w_done_nxt;
            end else if (rd_frame_start) begin
                r_rd_pend <= 1'b1;
            end
        end
    end

    assign cmd_valid  = (r_state == ST_CMD) && ddr_init_done;
    assign cmd_rw     = r_cmd_rw;
    assign cmd_addr   = r_cmd_addr;
    assign cmd_len    = r_cmd_len;
    assign wr_buf_sel = r_wr_buf_sel;
    assign rd_buf_sel = r_rd_buf_sel;
    assign busy       = (r_state == ST_WAIT);

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Scoreboard bench for ddr_frame_arbiter with a 100-word frame so
// frame-end clamping and wrap are reached quickly.
module tb_ddr_frame_arbiter;

    typedef struct {
        logic        rw;
        logic [23:0] addr;
        logic [6:0]  len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        wr_fs;
    logic        rd_fs;
    logic [9:0]  wr_lvl;
    logic [9:0]  rd_lvl;
    logic        cmd_ready;
    logic        cmd_done;
    logic        cmd_valid;
    logic        cmd_rw;
    logic [23:0] cmd_addr;
    logic [6:0]  cmd_len;
    logic        wr_buf_sel;
    logic        rd_buf_sel;
    logic        busy;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;
    int   rdy_dly = 5;
    bit   skip_done = 1'b0;

    ddr_frame_arbiter #(
        .FRAME_WORDS (100)
    ) dut (
        .ddr_clk        (clk),
        .ddr_rst        (rst),
        .ddr_init_done  (init_done),
        .wr_frame_start (wr_fs),
        .rd_frame_start (rd_fs),
        .wr_fifo_level  (wr_lvl),
        .rd_fifo_level  (rd_lvl),
        .cmd_ready      (cmd_ready),
        .cmd_done       (cmd_done),
        .cmd_valid      (cmd_valid),
        .cmd_rw         (cmd_rw),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .wr_buf_sel     (wr_buf_sel),
        .rd_buf_sel     (rd_buf_sel),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic push(input logic rw, input int addr, input int len);
        exp_t e;
        e.rw   = rw;
        e.addr = 24'(addr);
        e.len  = 7'(len);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_acc(input int t);
        int k = 0;
        while (n_acc < t && k < 400) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk($sformatf("accept_count_%0d", t), n_acc, t);
    endtask

    // Controller model: delayed ready, then cmd_done two cycles after accept.
    initial begin
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_valid) begin
                repeat (rdy_dly) @(negedge clk);
                cmd_ready = 1'b1;
                @(negedge clk);
                cmd_ready = 1'b0;
                repeat (2) @(negedge clk);
                if (!skip_done) cmd_done = 1'b1;
                @(negedge clk);
                cmd_done = 1'b0;
            end
        end
    end

    // Monitor: every valid cycle must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && cmd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cmd rw=%0d addr=%0d len=%0d",
                             cmd_rw, cmd_addr, cmd_len);
                end else begin
                    e = exp_q[0];
                    if (cmd_rw !== e.rw || cmd_addr !== e.addr ||
                        cmd_len !== e.len) begin
                        errors++;
                        $display("FAIL cmd%0d got rw=%0d addr=%0d len=%0d want rw=%0d addr=%0d len=%0d",
                                 n_acc + 1, cmd_rw, cmd_addr, cmd_len,
                                 e.rw, e.addr, e.len);
                    end
                    if (cmd_ready) begin
                        void'(exp_q.pop_front());
                        n_acc++;
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        init_done = 1'b0;
        wr_fs     = 1'b0;
        rd_fs     = 1'b0;
        wr_lvl    = 10'd200;
        rd_lvl    = 10'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_cyc(8);
        chk("rst_cmd_valid", int'(cmd_valid), 0);
        chk("rst_wr_buf_sel", int'(wr_buf_sel), 0);
        chk("rst_rd_buf_sel", int'(rd_buf_sel), 1);
        chk("rst_busy", int'(busy), 0);

        push(1'b0, 262144, 64);
        wr_lvl    = 10'd300;
        init_done = 1'b1;
        wait_acc(1);
        rdy_dly = 1;
        rd_lvl  = 10'd300;
        push(1'b1, 0, 64);
        push(1'b0, 262208, 36);
        push(1'b1, 64, 36);
        push(1'b0, 262144, 64);
        wait_acc(5);
        rd_lvl = 10'd500;
        wait_cyc(20);
        chk("no_wr_after_wrap", n_acc, 5);
        chk("idle_cmd_valid", int'(cmd_valid), 0);
        chk("wr_sel_before_fs", int'(wr_buf_sel), 0);

        push(1'b0, 262208, 36);
        rd_lvl = 10'd300;
        wait_acc(6);
        @(negedge clk);
        #2;
        rd_fs = 1'b1;
        @(negedge clk);
        rd_fs = 1'b0;
        #2;
        chk("rd_fs_deferred_sel", int'(rd_buf_sel), 1);
        chk("rd_fs_deferred_busy", int'(busy), 1);
        push(1'b0, 0, 64);
        wait_acc(7);
        rd_lvl = 10'd500;
        wait_cyc(8);
        chk("rd_sel_after_fs", int'(rd_buf_sel), 0);

        push(1'b1, 262144, 64);
        wr_fs = 1'b1;
        @(negedge clk);
        wr_fs = 1'b0;
        #2;
        chk("wr_sel_after_fs", int'(wr_buf_sel), 1);
        wait_acc(8);
        wr_lvl = 10'd0;
        wait_cyc(8);

        skip_done = 1'b1;
        push(1'b1, 262208, 36);
        wr_lvl = 10'd300;
        wait_acc(9);
        wr_lvl = 10'd0;
        @(negedge clk);
        #2;
        chk("busy_in_wait", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(cmd_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_wr_sel", int'(wr_buf_sel), 0);
        chk("async_rst_rd_sel", int'(rd_buf_sel), 1);
        skip_done = 1'b0;
        rd_lvl    = 10'd0;
        push(1'b0, 262144, 64);
        @(negedge clk);
        rst = 1'b0;
        wait_acc(10);
        rd_lvl = 10'd500;
        wait_cyc(8);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
